// File: rtl/parity_ctrl_pkg.sv
// Shared encodings for the parity engine controller: operation modes and FSM states.
package parity_ctrl_pkg;

  localparam logic [1:0] MODE_GEN_EVEN = 2'b00;
  localparam logic [1:0] MODE_GEN_ODD  = 2'b01;
  localparam logic [1:0] MODE_CHK_EVEN = 2'b10;
  localparam logic [1:0] MODE_CHK_ODD  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/parity_core.sv
// Combinational parity generate/check core; the parity bit sits at the MSB of data_out.
module parity_core
  import parity_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_in,
  output logic [DATA_W:0]   data_out,
  output logic              error
);

  logic x;

  always_comb begin
    x        = ^data;
    data_out = {1'b0, data};
    error    = 1'b0;
    case (mode)
      MODE_GEN_EVEN: data_out = {x, data};
      MODE_GEN_ODD:  data_out = {~x, data};
      // check modes echo the received parity bit rather than a recomputed one
      MODE_CHK_EVEN: begin
        data_out = {parity_in, data};
        error    = x ^ parity_in;
      end
      MODE_CHK_ODD: begin
        data_out = {parity_in, data};
        error    = ~(x ^ parity_in);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/parity_engine_ctrl.sv
// Two-port round-robin front end sharing one parity core, with a registered response channel.
// Optional sticky error flag with err_clr is enabled by defining PARITY_STICKY_ERR_EN.
module parity_engine_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_mode,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_parity,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_mode,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_parity,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W:0]   rsp_data,
  output logic              rsp_error,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
`ifdef PARITY_STICKY_ERR_EN
  ,
  input  logic              err_clr,
  output logic              err_sticky
`endif
);

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        op_mode_q, op_mode_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic              op_par_q, op_par_d;
  logic              op_id_q, op_id_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W:0]   rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              grant0, grant1;
  logic [DATA_W:0]   core_data;
  logic              core_error;
  logic              fail_evt;

  parity_core #(.DATA_W(DATA_W)) u_core (
    .mode      (op_mode_q),
    .data      (op_data_q),
    .parity_in (op_par_q),
    .data_out  (core_data),
    .error     (core_error)
  );

  // ptr_q == 0 favours requester 0 when both are valid
  always_comb begin
    grant0 = (state_q == ST_IDLE) && req0_valid && (!req1_valid || !ptr_q);
    grant1 = (state_q == ST_IDLE) && req1_valid && (!req0_valid || ptr_q);
    fail_evt = (state_q == ST_EXEC) && core_error;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_mode_d   = op_mode_q;
    op_data_d   = op_data_q;
    op_par_d    = op_par_q;
    op_id_d     = op_id_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          op_mode_d = req0_mode;
          op_data_d = req0_data;
          op_par_d  = req0_parity;
          op_id_d   = 1'b0;
          ptr_d     = 1'b1;
          state_d   = ST_EXEC;
        end else if (grant1) begin
          op_mode_d = req1_mode;
          op_data_d = req1_data;
          op_par_d  = req1_parity;
          op_id_d   = 1'b1;
          ptr_d     = 1'b0;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d    = op_id_q;
        rsp_data_d  = core_data;
        rsp_error_d = core_error;
        if (core_error && (err_count_q != {CNT_W{1'b1}})) begin
          err_count_d = err_count_q + 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      op_mode_q   <= '0;
      op_data_q   <= '0;
      op_par_q    <= 1'b0;
      op_id_q     <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_mode_q   <= op_mode_d;
      op_data_q   <= op_data_d;
      op_par_q    <= op_par_d;
      op_id_q     <= op_id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef PARITY_STICKY_ERR_EN
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (fail_evt) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`else
  logic unused_fail_evt;
  assign unused_fail_evt = fail_evt;
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_engine_ctrl.sv
// Directed self-checking bench for parity_engine_ctrl: latency, arithmetic, backpressure,
// round-robin alternation, reset mid-operation and counter saturation.
module tb_parity_engine_ctrl;

  localparam int CNT_W  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_parity;
  logic [1:0]        req0_mode;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_ready, req1_parity;
  logic [1:0]        req1_mode;
  logic [DATA_W-1:0] req1_data;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
  logic [DATA_W:0]   rsp_data;
  logic [CNT_W-1:0]  err_count;
`ifdef PARITY_STICKY_ERR_EN
  logic              err_clr = 1'b0;
  logic              err_sticky;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  parity_engine_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_mode   (req0_mode),
    .req0_data   (req0_data),
    .req0_parity (req0_parity),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_mode   (req1_mode),
    .req1_data   (req1_data),
    .req1_parity (req1_parity),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .err_count   (err_count),
    .busy        (busy)
`ifdef PARITY_STICKY_ERR_EN
    ,
    .err_clr     (err_clr),
    .err_sticky  (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation on a port and returns 1ns after the accepting edge.
  task automatic applyStimulus(input string tag, input bit id, input logic [1:0] mode,
                               input logic [7:0] data, input logic par);
    bit granted = 0;
    if (id == 1'b0) begin
      req0_mode = mode; req0_data = data; req0_parity = par; req0_valid = 1'b1;
    end else begin
      req1_mode = mode; req1_data = data; req1_parity = par; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      if ((id == 1'b0) ? req0_ready : req1_ready) granted = 1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!granted) checkOutput({tag, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runOp(input string tag, input bit id, input logic [1:0] mode,
                       input logic [7:0] data, input logic par,
                       input logic [8:0] expData, input logic expErr, input logic [7:0] expCnt);
    applyStimulus(tag, id, mode, data, par);
    checkOutput({tag, "_valid_n1"}, rsp_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_n2"}, rsp_valid, 1'b1);
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkOutput({tag, "_error"}, rsp_error, expErr);
    checkOutput({tag, "_id"}, rsp_id, id);
    checkOutput({tag, "_count"}, err_count, expCnt);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, rsp_valid, 1'b0);
    checkOutput({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int gid[5];
  int gcyc[5];
  int ngrant;
  logic [8:0] heldData;

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_mode = 0; req0_data = 0; req0_parity = 0;
    req1_valid = 0; req1_mode = 0; req1_data = 0; req1_parity = 0;
    rsp_ready = 0;
    @(posedge clk); #1;
    doReset();

    checkOutput("rst_valid", rsp_valid, 1'b0);
    checkOutput("rst_id", rsp_id, 1'b0);
    checkOutput("rst_data", rsp_data, 9'h000);
    checkOutput("rst_error", rsp_error, 1'b0);
    checkOutput("rst_count", err_count, 8'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready0", req0_ready, 1'b0);
    checkOutput("rst_ready1", req1_ready, 1'b0);

    runOp("r0_geneven_AA", 1'b0, 2'b00, 8'hAA, 1'b0, 9'h0AA, 1'b0, 8'd0);
    runOp("r1_geneven_7A", 1'b1, 2'b00, 8'h7A, 1'b0, 9'h17A, 1'b0, 8'd0);
    runOp("r1_genodd_AA",  1'b1, 2'b01, 8'hAA, 1'b0, 9'h1AA, 1'b0, 8'd0);
    runOp("chkeven_p0",    1'b0, 2'b10, 8'h7A, 1'b0, 9'h07A, 1'b1, 8'd1);
`ifdef PARITY_STICKY_ERR_EN
    checkOutput("sticky_set", err_sticky, 1'b1);
`endif
    runOp("chkeven_p1",    1'b0, 2'b10, 8'h7A, 1'b1, 9'h17A, 1'b0, 8'd1);

    // Check-odd failure held under backpressure with a competing request pending
    applyStimulus("chkodd_hold", 1'b0, 2'b11, 8'h7A, 1'b1);
    @(posedge clk); #1;
    checkOutput("hold_valid", rsp_valid, 1'b1);
    checkOutput("hold_error", rsp_error, 1'b1);
    checkOutput("hold_count", err_count, 8'd2);
    heldData = 9'h17A;
    req1_mode = 2'b00; req1_data = 8'h55; req1_parity = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid_stable", rsp_valid, 1'b1);
      checkOutput("hold_data_stable", rsp_data, heldData);
      checkOutput("hold_error_stable", rsp_error, 1'b1);
      checkOutput("hold_id_stable", rsp_id, 1'b0);
      checkOutput("hold_no_ready1", req1_ready, 1'b0);
      checkOutput("hold_busy", busy, 1'b1);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("hold_release", rsp_valid, 1'b0);

    // Both requesters valid continuously with rsp_ready high
    doReset();
    req0_mode = 2'b10; req0_data = 8'h7A; req0_parity = 1'b0; req0_valid = 1'b1;
    req1_mode = 2'b10; req1_data = 8'h7A; req1_parity = 1'b0; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    ngrant = 0;
    for (int i = 0; i < 40 && ngrant < 5; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        gid[ngrant]  = req1_ready ? 1 : 0;
        gcyc[ngrant] = cyc;
        ngrant++;
      end
      if (ngrant < 5) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rr_grant_total", ngrant, 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr_grant_id%0d", k), gid[k], k % 2);
      if (k > 0) checkOutput($sformatf("rr_spacing%0d", k), gcyc[k] - gcyc[k-1], 3);
    end
    checkOutput("rr_count", err_count, 8'd4);
    @(posedge clk); #1;
    checkOutput("rr_in_exec", busy, 1'b1);
    checkOutput("rr_exec_valid", rsp_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_valid", rsp_valid, 1'b0);
    checkOutput("midrst_count", err_count, 8'd0);
    checkOutput("midrst_busy", busy, 1'b0);
    #1;
    checkOutput("midrst_grant0", req0_ready, 1'b1);
    checkOutput("midrst_grant1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Counter saturation: ~266 failing checks back to back
    doReset();
    req0_mode = 2'b10; req0_data = 8'h7A; req0_parity = 1'b0; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    checkOutput("sat_count", err_count, 8'hFF);
    req0_valid = 1'b0;
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
